scalar_seq: RTL

Scalar instruction sequencer for one CGRA tile. It holds a small instruction memory, a scalar register file and a program counter. It decodes each instruction into operands and an opcode for the tile's combinational scalar PE, then writes back the PE result or takes a branch on the PE's equality flag. A host loads the program, pulses start, and waits for done.

---
 rtl/cgra_scalar_pkg.sv | 47 ++++
 rtl/scalar_regfile.sv | 44 ++++
 rtl/scalar_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cgra_scalar_pkg.sv
// ------------------------------------------------------------------
// cgra_scalar_pkg -- shared types and constants for the scalar sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cgra_scalar_pkg;

  localparam int dwidth_int = 32;

  localparam logic [2:0] LUI       = 3'b000;
  localparam logic [2:0] ADDI      = 3'b001;
  localparam logic [2:0] BEQ       = 3'b010;
  localparam logic [2:0] HALT      = 3'b111;
  localparam logic [2:0] NOP_DRIVE = 3'b011;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 29;
  localparam int RD_HI  = 28;
  localparam int RD_LO  = 26;
  localparam int RS1_HI = 25;
  localparam int RS1_LO = 23;
  localparam int RS2_HI = 22;
  localparam int RS2_LO = 20;
  localparam int IMM_HI = 19;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [dwidth_int-1:0] sext_imm(input logic [31:0] instr);
    return {{(dwidth_int-20){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
  endfunction

  function automatic logic [dwidth_int-1:0] lui_value(input logic [31:0] instr);
    logic [31:0] v;
    v = {instr[IMM_HI:IMM_LO], 12'h000};
    return v[dwidth_int-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/scalar_regfile.sv
// ------------------------------------------------------------------
// scalar_regfile -- scalar registers, r0 hardwired to zero
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module scalar_regfile
  import cgra_scalar_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [2:0]            waddr_i,
  input  logic [dwidth_int-1:0] wdata_i,
  input  logic [2:0]            raddr1_i,
  input  logic [2:0]            raddr2_i,
  input  logic [2:0]            dbg_raddr_i,
  output logic [dwidth_int-1:0] rdata1_o,
  output logic [dwidth_int-1:0] rdata2_o,
  output logic [dwidth_int-1:0] dbg_rdata_o
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [dwidth_int-1:0] regs_q [NUM_REGS];

  assign rdata1_o    = regs_q[raddr1_i[AW-1:0]];
  assign rdata2_o    = regs_q[raddr2_i[AW-1:0]];
  assign dbg_rdata_o = regs_q[dbg_raddr_i[AW-1:0]];

  // regs_q[0] is cleared by reset and never written, so r0 always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i[AW-1:0] != '0)) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scalar_seq.sv
// ------------------------------------------------------------------
// scalar_seq -- CGRA tile scalar sequencer: imem, pc, FSM, watchdog
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module scalar_seq
  import cgra_scalar_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int IMEM_DEPTH = 32,
  parameter int MAX_STEPS  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [15:0]                   step_cnt,
  input  logic [2:0]                    rf_raddr,
  output logic [dwidth_int-1:0]         rf_rdata,
  output logic [dwidth_int-1:0]         pe_inp1,
  output logic [dwidth_int-1:0]         pe_inp2,
  output logic [dwidth_int-1:0]         pe_imm,
  output logic [2:0]                    pe_op,
  input  logic [dwidth_int-1:0]         pe_out1,
  input  logic                          pe_flag_eq
);

  localparam int          PW         = $clog2(IMEM_DEPTH);
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  state_e                state_q, state_d;
  logic [31:0]           imem_q [IMEM_DEPTH];
  logic [31:0]           instr_q;
  logic [PW-1:0]         pc_q, pc_d;
  logic [15:0]           step_cnt_q, step_cnt_d;
  logic                  err_q, err_d;

  logic [2:0]            op, rd, rs1, rs2;
  logic [dwidth_int-1:0] imm_sext, rs1_val, rs2_val, rf_wdata;
  logic                  is_halt, wd_hit, rf_we;

  assign op       = instr_q[OP_HI:OP_LO];
  assign rd       = instr_q[RD_HI:RD_LO];
  assign rs1      = instr_q[RS1_HI:RS1_LO];
  assign rs2      = instr_q[RS2_HI:RS2_LO];
  assign imm_sext = sext_imm(instr_q);
  assign is_halt  = (op == HALT);
  // the instruction now in EXEC is the one that brings the count to the limit
  assign wd_hit   = ((step_cnt_q + 16'd1) >= STEP_LIMIT);

  assign rf_we    = (state_q == ST_EXEC) && ((op == LUI) || (op == ADDI));
  assign rf_wdata = (op == LUI) ? lui_value(instr_q) : pe_out1;

  scalar_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd),
    .wdata_i    (rf_wdata),
    .raddr1_i   (rs1),
    .raddr2_i   (rs2),
    .dbg_raddr_i(rf_raddr),
    .rdata1_o   (rs1_val),
    .rdata2_o   (rs2_val),
    .dbg_rdata_o(rf_rdata)
  );

  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && imem_we) imem_q[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = (is_halt || wd_hit) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    pe_inp1 = '0;
    pe_inp2 = '0;
    pe_imm  = '0;
    pe_op   = NOP_DRIVE;
    case (state_q)
      ST_FETCH: busy = 1'b1;
      ST_EXEC: begin
        busy    = 1'b1;
        pe_inp1 = rs1_val;
        pe_inp2 = rs2_val;
        pe_imm  = imm_sext;
        pe_op   = op;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_q;
    if ((state_q == ST_IDLE) && start) begin
      pc_d       = '0;
      step_cnt_d = '0;
      err_d      = 1'b0;
    end else if (state_q == ST_EXEC) begin
      step_cnt_d = step_cnt_q + 16'd1;
      pc_d       = ((op == BEQ) && pe_flag_eq) ? (pc_q + imm_sext[PW-1:0]) : (pc_q + PW'(1));
      if (wd_hit && !is_halt) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      step_cnt_q <= '0;
      err_q      <= 1'b0;
      instr_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      step_cnt_q <= step_cnt_d;
      err_q      <= err_d;
      if (state_q == ST_FETCH) instr_q <= imem_q[pc_q];
    end
  end

  assign step_cnt = step_cnt_q;
  assign err      = err_q;

endmodule

`default_nettype wire
